// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared defaults and FSM state encoding for the sequence capture.
// Revision : 1.0
// ============================================================================
package seq_pkg;

  localparam int c_def_width = 32;
  localparam int c_def_idx_w = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : seq_fifo
// Brief    : Register-array FIFO, head read from storage, push/pop when full.
// Revision : 1.0
// ============================================================================
module seq_fifo #(
  parameter int DW    = 40,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]   r_wr_ptr;
  logic [c_aw:0]   r_rd_ptr;
  logic [DW-1:0]   r_mem [DEPTH];
  logic            w_do_push;
  logic            w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // When full, the slot being written is the one being popped this edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[c_aw-1:0]] <= i_wdata;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_capture.sv
`default_nettype none
// ============================================================================
// Module   : seq_capture
// Brief    : Captures N consecutive generator terms, tags index, flags wrap.
// Revision : 1.0
// ============================================================================
module seq_capture
  import seq_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int DEPTH = 4,
  parameter int IDX_W = c_def_idx_w
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             start,
  input  logic [IDX_W-1:0] count,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             dropped
);

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_remaining, w_remaining_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [WIDTH-1:0]   r_prev, w_prev_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_dropped, w_dropped_nxt;
  logic               r_zero_done, w_zero_done_nxt;

  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_can_push;
  logic               w_push;
  logic [IDX_W+WIDTH-1:0] w_rdata;

  assign w_pop      = !w_empty && out_ready;
  assign w_can_push = !w_full || w_pop;

  seq_fifo #(
    .DW    (IDX_W + WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({r_idx, in_data}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_idx       <= '0;
      r_prev      <= '0;
      r_ovf       <= 1'b0;
      r_dropped   <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_idx       <= w_idx_nxt;
      r_prev      <= w_prev_nxt;
      r_ovf       <= w_ovf_nxt;
      r_dropped   <= w_dropped_nxt;
      r_zero_done <= w_zero_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_idx_nxt       = r_idx;
    w_prev_nxt      = r_prev;
    w_ovf_nxt       = r_ovf;
    w_dropped_nxt   = r_dropped;
    w_zero_done_nxt = 1'b0;
    w_push          = 1'b0;
    done            = r_zero_done;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_ovf_nxt     = 1'b0;
          w_dropped_nxt = 1'b0;
          if (count != '0) begin
            w_remaining_nxt = count;
            w_idx_nxt       = '0;
            w_state_nxt     = ST_CAPTURE;
          end else begin
            w_zero_done_nxt = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        w_push = w_can_push;
        if (!w_can_push) begin
          w_dropped_nxt = 1'b1;
        end
        // First term of a capture has no predecessor to compare against.
        if ((r_idx != '0) && (in_data < r_prev)) begin
          w_ovf_nxt = 1'b1;
        end
        w_prev_nxt      = in_data;
        w_idx_nxt       = r_idx + 1'b1;
        w_remaining_nxt = r_remaining - 1'b1;
        if (r_remaining == IDX_W'(1)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          done        = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign out_data  = w_rdata[WIDTH-1:0];
  assign out_idx   = w_rdata[IDX_W+WIDTH-1:WIDTH];
  assign out_valid = !w_empty;
  assign busy      = (r_state == ST_CAPTURE) || (r_state == ST_DRAIN);
  assign ovf       = r_ovf;
  assign dropped   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_seq_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_capture
// Brief    : Directed self-checking bench for seq_capture.
// Revision : 1.0
// ============================================================================
module tb_seq_capture;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        start;
  logic [7:0]  count;
  logic [31:0] out_data;
  logic [7:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        dropped;

  int checks   = 0;
  int failures = 0;

  logic [31:0] trib [8];

  seq_capture #(.WIDTH(32), .DEPTH(4), .IDX_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .start     (start),
    .count     (count),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .dropped   (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    trib[0] = 0; trib[1] = 1; trib[2] = 1; trib[3] = 2;
    trib[4] = 4; trib[5] = 7; trib[6] = 13; trib[7] = 24;
    rst = 1'b0; start = 1'b0; count = '0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dropped", dropped, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Nominal capture of the tribonacci stream
    start = 1'b1; count = 8'd5;
    tick();
    start = 1'b0;
    chk("nom_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      in_data = trib[i];
      tick();
      chk("nom_valid", out_valid, 1);
      chk("nom_idx", out_idx, i);
      chk("nom_data", out_data, trib[i]);
    end
    chk("nom_done_early", done, 0);
    tick();
    chk("nom_done", done, 1);
    chk("nom_empty", out_valid, 0);
    chk("nom_busy_drain", busy, 1);
    tick();
    chk("nom_done_clr", done, 0);
    chk("nom_idle", busy, 0);
    chk("nom_ovf", ovf, 0);
    chk("nom_dropped", dropped, 0);

    // Backpressure with drops
    out_ready = 1'b0;
    start = 1'b1; count = 8'd6;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'd100 + i;
      tick();
    end
    chk("bp_dropped", dropped, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_head_idx", out_idx, 0);
    chk("bp_head_data", out_data, 100);
    chk("bp_done", done, 0);
    tick();
    chk("bp_hold_idx", out_idx, 0);
    chk("bp_hold_data", out_data, 100);
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("bp_idx", out_idx, k);
      chk("bp_data", out_data, 100 + k);
    end
    tick();
    chk("bp_done_pulse", done, 1);
    chk("bp_empty", out_valid, 0);
    tick();
    chk("bp_idle", busy, 0);
    chk("bp_dropped_sticky", dropped, 1);

    // Full FIFO with simultaneous push/pop, plus start ignored while busy
    out_ready = 1'b0;
    start = 1'b1; count = 8'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_data = 32'd200 + i;
      if (i == 4) out_ready = 1'b1;
      if (i == 5) begin
        start = 1'b1; count = 8'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("sim_head_idx", out_idx, 3);
    chk("sim_head_data", out_data, 203);
    chk("sim_dropped", dropped, 0);
    chk("sim_busy", busy, 1);
    for (int k = 4; k < 7; k++) begin
      tick();
      chk("sim_idx", out_idx, k);
      chk("sim_data", out_data, 200 + k);
    end
    chk("sim_done_early", done, 0);
    tick();
    chk("sim_done", done, 1);
    tick();
    chk("sim_idle", busy, 0);

    // Arithmetic wrap detection
    out_ready = 1'b1;
    start = 1'b1; count = 8'd2;
    tick();
    start = 1'b0;
    in_data = 32'hFFFF_FFF0;
    tick();
    chk("ovf_first", ovf, 0);
    in_data = 32'h0000_0010;
    tick();
    chk("ovf_set", ovf, 1);
    chk("ovf_idx", out_idx, 1);
    chk("ovf_data", out_data, 32'h10);
    tick();
    chk("ovf_done", done, 1);
    chk("ovf_at_done", ovf, 1);
    tick();
    chk("ovf_idle", busy, 0);
    chk("ovf_sticky", ovf, 1);

    // count = 0 command
    start = 1'b1; count = 8'd0;
    tick();
    start = 1'b0;
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_ovf_clr", ovf, 0);
    tick();
    chk("z_done_clr", done, 0);

    // Asynchronous reset mid-capture
    out_ready = 1'b0;
    start = 1'b1; count = 8'd5;
    tick();
    start = 1'b0;
    in_data = 32'd50;
    tick();
    in_data = 32'd20;
    tick();
    chk("ar_pre_valid", out_valid, 1);
    chk("ar_pre_ovf", ovf, 1);
    chk("ar_pre_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_done", done, 0);
    chk("ar_data", out_data, 0);
    tick();
    chk("ar_no_done", done, 0);
    rst = 1'b1;
    tick();
    chk("ar_post_busy", busy, 0);
    chk("ar_post_done", done, 0);
    chk("ar_post_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
